// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad front end: scanner state encoding,
// special key codes and the row/column to key-code map.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        EMIT,
        WAIT_RELEASE
    } state_t;

    localparam logic [3:0] KEY_NONE = 4'hF;
    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    // row_sel and col_sel are one-hot; anything else maps to KEY_NONE
    function automatic logic [3:0] key_code(input logic [3:0] row_sel, input logic [2:0] col_sel);
        int r;
        int c;
        r = 0;
        c = 0;
        case (row_sel)
            4'b0001: r = 0;
            4'b0010: r = 1;
            4'b0100: r = 2;
            4'b1000: r = 3;
            default: return KEY_NONE;
        endcase
        case (col_sel)
            3'b001:  c = 0;
            3'b010:  c = 1;
            3'b100:  c = 2;
            default: return KEY_NONE;
        endcase
        if (r == 3) begin
            case (c)
                0:       return KEY_STAR;
                1:       return 4'h0;
                default: return KEY_HASH;
            endcase
        end
        return 4'(r * 3 + c + 1);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle: row returns in, column drive and key event outputs.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [2:0] col;
    logic [3:0] key;
    logic       key_valid;
    logic       pressed;

    modport slave  (input row, output col, output key, output key_valid, output pressed);
    modport master (output row, input col, input key, input key_valid, input pressed);
endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchroniser with asynchronous active-high reset.
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column scan, press/release debounce and key encoding
// with one single-cycle key_valid pulse per accepted press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.slave   kp
);
    localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

    state_t        state, state_n;
    logic [3:0]    srow;
    logic [2:0]    col_q, col_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    cap_row, cap_n;
    logic [3:0]    key_q, key_n;
    logic          kv_q, kv_n;
    logic          pressed_q, pressed_n;
    logic [2:0]    col_next;

    keypad_sync #(.WIDTH(4)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kp.row),
        .q     (srow)
    );

    assign col_next = {col_q[1:0], col_q[2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            col_q     <= 3'b001;
            cnt       <= '0;
            cap_row   <= '0;
            key_q     <= KEY_NONE;
            kv_q      <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            state     <= state_n;
            col_q     <= col_n;
            cnt       <= cnt_n;
            cap_row   <= cap_n;
            key_q     <= key_n;
            kv_q      <= kv_n;
            pressed_q <= pressed_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            SCAN:         if (cnt == SCAN_LAST && $onehot(srow)) state_n = DEBOUNCE;
            DEBOUNCE: begin
                if (srow != cap_row)     state_n = SCAN;
                else if (cnt == DEB_LAST) state_n = EMIT;
            end
            EMIT:         state_n = WAIT_RELEASE;
            WAIT_RELEASE: if (srow == '0 && cnt == DEB_LAST) state_n = SCAN;
            default:      state_n = SCAN;
        endcase
    end

    // key/key_valid/pressed are loaded on the DEBOUNCE->EMIT edge so the
    // registered pulse is visible for exactly the one cycle spent in EMIT.
    always_comb begin
        col_n     = col_q;
        cnt_n     = cnt;
        cap_n     = cap_row;
        key_n     = key_q;
        kv_n      = 1'b0;
        pressed_n = pressed_q;
        case (state)
            SCAN: begin
                if (cnt == SCAN_LAST) begin
                    cnt_n = '0;
                    if ($onehot(srow)) cap_n = srow;
                    else               col_n = col_next;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DEBOUNCE: begin
                if (srow != cap_row) begin
                    cnt_n = '0;
                    col_n = col_next;
                end else if (cnt == DEB_LAST) begin
                    cnt_n     = '0;
                    key_n     = key_code(cap_row, col_q);
                    kv_n      = 1'b1;
                    pressed_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            EMIT: cnt_n = '0;
            WAIT_RELEASE: begin
                if (srow != '0) begin
                    cnt_n = '0;
                end else if (cnt == DEB_LAST) begin
                    cnt_n     = '0;
                    pressed_n = 1'b0;
                    col_n     = col_next;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: cnt_n = '0;
        endcase
    end

    assign kp.col       = col_q;
    assign kp.key       = key_q;
    assign kp.key_valid = kv_q;
    assign kp.pressed   = pressed_q;
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Matrix-keypad front end that drives the digit-entry lock FSM. Scans a 4-row x 3-column keypad, synchronises and debounces the row returns, and encodes each accepted press into a 4-bit key code. Emits exactly one single-cycle valid pulse per physical press. The lock consumes these codes downstream.

Parameters:
SCAN_CYCLES, 4, clock cycles each column is driven during scanning; must be >= 3 to cover synchroniser latency.
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a press and, separately, a release.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
row  input  4  keypad row returns, active-high, asynchronous to clk.
col  output  3  one-hot active-high column drive.
key  output  4  last accepted key code, held between presses.
key_valid  output  1  high for exactly one cycle when key is updated.
pressed  output  1  high from the accept cycle until the release is debounced.

Behaviour:
- Reset values (asynchronous): col=3'b001, key=4'hF, key_valid=0, pressed=0. State is SCAN, all counters are 0, synchroniser flops are 0.
- row passes through a 2-flop synchroniser. All decisions below use the synchronised value (srow).
- Code map (row r, col c):
  - r0: 1, 2, 3
  - r1: 4, 5, 6
  - r2: 7, 8, 9
  - r3: *=4'hA, 0=4'h0, #=4'hB
  - 4'hF means no key, reset value only.
- SCAN state:
  - col advances 001->010->100->001 every SCAN_CYCLES cycles.
  - srow is sampled only on the last cycle of each column dwell.
  - Exactly one srow bit set: capture that row and the current col, freeze col, clear counter, go to DEBOUNCE.
  - Zero bits or two or more bits set: no capture; advance col as normal (multi-key is rejected).
- DEBOUNCE state:
  - col stays frozen.
  - Each cycle srow equals the captured row: counter increments.
  - Any mismatch: return to SCAN, advancing to the next column.
  - Counter reaches DEBOUNCE_CYCLES-1: go to EMIT.
- EMIT state, one cycle:
  - key <= code(captured row, col); key_valid=1 for this single cycle (registered output); pressed <= 1.
  - Next state is WAIT_RELEASE.
- WAIT_RELEASE state:
  - col stays frozen; the counter counts consecutive cycles with srow==0, and any nonzero srow clears it.
  - Counter reaches DEBOUNCE_CYCLES-1: pressed <= 0, go to SCAN, advancing to the next column.
  - A key held indefinitely never produces a second pulse.
- key holds its value after key_valid drops. The consumer must qualify key with key_valid.
- Minimum press-to-pulse latency: the key's column dwell sample point + DEBOUNCE_CYCLES + 1 cycles. The 2-cycle synchroniser delay is absorbed by SCAN_CYCLES >= 3.
- Reset mid-operation: all outputs return to reset values immediately and no pulse is issued for the interrupted press. A key still held when reset deasserts is treated as a new press and emitted once.
- Counter widths: $clog2 of max(SCAN_CYCLES, DEBOUNCE_CYCLES). No counter may wrap; each is cleared on every state entry.

Decomposition:
- Shared package keypad_pkg holds:
  - state enum SCAN/DEBOUNCE/EMIT/WAIT_RELEASE;
  - constants KEY_NONE=4'hF, KEY_STAR=4'hA, KEY_HASH=4'hB;
  - the row/col-to-code function.
- One sub-module: keypad_sync, a parameterised-width 2-flop synchroniser with async reset. It is instantiated on row.

Test Plan (SCAN_CYCLES=4, DEBOUNCE_CYCLES=16):
1. Hold key '3' (row[0] responding only while col==3'b100) for 200 cycles, then release -> exactly one key_valid pulse with key=4'h3. pressed stays high until 16 cycles after release. No further pulse.
2. Press and release 3,3,5,2,5,6 in turn, each held 60 cycles with 60-cycle gaps -> six pulses carrying 3,3,5,2,5,6 in order. key holds 4'h6 afterwards.
3. Bounce on key '5': row[1] toggles every 3 cycles for 30 cycles, then stays stable -> no pulse during bouncing, then exactly one pulse with key=4'h5. A separate burst of 10-cycle presses only -> no pulse.
4. Keys '1' and '4' held together (row[0] and row[1] while col==3'b001) -> no pulse. Releasing '4' -> one pulse with key=4'h1.
5. Assert reset while DEBOUNCE is 8 cycles into a press of '#' -> key=4'hF, key_valid=0, pressed=0, col=3'b001 immediately. Keep the key held through reset deassertion -> one pulse with key=4'hB.
6. Press '*' then '0' -> pulses with key=4'hA then key=4'h0.
